fms_norm_round: RTL and testbench

//  Post-processing stage downstream of the fused multiply-subtract datapath (A*B - C). Accepts the raw

---
 rtl/fp_pkg.sv | 38 +++
 rtl/fp_round_rne.sv | 49 ++++
 rtl/fms_norm_round.sv | 121 ++++++++++++
 tb/tb_fms_norm_round.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, special-case codes, FSM encoding and flag indices for the
// FMS normalize/round stage.
package fp_pkg;

  localparam int unsigned MANT_W = 48;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned XEXP_W = EXP_W + 1;
  localparam int unsigned FL_W   = 5;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic signed [XEXP_W-1:0] EXP_MAX_X = XEXP_W'(EXP_MAX);
  localparam logic signed [XEXP_W-1:0] ONE_X     = XEXP_W'(1);

  typedef enum logic [1:0] {
    SP_NORM = 2'b00,
    SP_ZERO = 2'b01,
    SP_INF  = 2'b10,
    SP_NAN  = 2'b11
  } special_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit positions within {infinity, zero, overflow, underflow, inexact}
  localparam int unsigned FL_INF  = 4;
  localparam int unsigned FL_ZERO = 3;
  localparam int unsigned FL_OVF  = 2;
  localparam int unsigned FL_UNF  = 1;
  localparam int unsigned FL_NX   = 0;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even and IEEE-754 single packing of a normalized
// (or subnormal, exp==1) magnitude.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [46:0]              mant,
  input  logic                     sticky,
  input  logic signed [XEXP_W-1:0] exp,
  input  logic                     sign,
  output logic [31:0]              word,
  output logic [FL_W-1:0]          flags
);

  logic                     l_bit, g_bit, s_bit, inc, hidden, nx, tiny;
  logic [24:0]              sum;
  logic signed [XEXP_W-1:0] exp_r;
  logic [22:0]              frac;
  logic [7:0]               efield;

  always_comb begin
    word   = '0;
    flags  = '0;
    l_bit  = mant[23];
    g_bit  = mant[22];
    s_bit  = (|mant[21:0]) | sticky;
    inc    = g_bit & (s_bit | l_bit);
    sum    = {1'b0, mant[46:23]} + 25'(inc);
    // A carry out of the significand bumps the exponent and clears the fraction
    exp_r  = exp + XEXP_W'(sum[24]);
    frac   = sum[24] ? 23'b0 : sum[22:0];
    hidden = sum[24] | sum[23];
    nx     = g_bit | s_bit;
    tiny   = ~mant[46];
    efield = 8'h00;
    if (exp_r >= EXP_MAX_X) begin
      word          = {sign, 8'hFF, 23'b0};
      flags[FL_OVF] = 1'b1;
      flags[FL_NX]  = 1'b1;
      flags[FL_INF] = 1'b1;
    end else begin
      efield         = hidden ? exp_r[7:0] : 8'h00;
      word           = {sign, efield, frac};
      flags[FL_NX]   = nx;
      flags[FL_UNF]  = tiny & nx;
      flags[FL_ZERO] = ~|{efield, frac};
    end
  end

endmodule

// File: rtl/fms_norm_round.sv
// Normalize (one bit per cycle), round RNE and pack the raw A*B-C difference
// into an IEEE-754 single with status flags. One transaction in flight.
module fms_norm_round
  import fp_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              IN_SIGN,
  input  logic [EXP_W-1:0]  IN_EXP,
  input  logic [MANT_W-1:0] IN_MANT,
  input  logic              IN_STICKY,
  input  logic [1:0]        IN_SPECIAL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [31:0]       OUT_FMSUB,
  output logic [FL_W-1:0]   OUT_FLAGS
);

  state_e                   state;
  logic                     sign_q;
  logic signed [XEXP_W-1:0] exp_q;
  logic [MANT_W-1:0]        mant_q;
  logic                     sticky_q;
  logic [31:0]              rnd_word;
  logic [FL_W-1:0]          rnd_flags;

  fp_round_rne u_round (
    .mant   (mant_q[46:0]),
    .sticky (sticky_q),
    .exp    (exp_q),
    .sign   (sign_q),
    .word   (rnd_word),
    .flags  (rnd_flags)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      OUT_FMSUB <= '0;
      OUT_FLAGS <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      sticky_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (IN_VALID) begin
            sign_q   <= IN_SIGN;
            exp_q    <= {IN_EXP[EXP_W-1], IN_EXP};
            mant_q   <= IN_MANT;
            sticky_q <= IN_STICKY;
            IN_READY <= 1'b0;
            case (special_e'(IN_SPECIAL))
              SP_ZERO: begin
                OUT_FMSUB <= {IN_SIGN, 31'b0};
                OUT_FLAGS <= FL_W'(1) << FL_ZERO;
                OUT_VALID <= 1'b1;
                state     <= ST_DONE;
              end
              SP_INF: begin
                OUT_FMSUB <= {IN_SIGN, 8'hFF, 23'b0};
                OUT_FLAGS <= FL_W'(1) << FL_INF;
                OUT_VALID <= 1'b1;
                state     <= ST_DONE;
              end
              SP_NAN: begin
                OUT_FMSUB <= QNAN;
                OUT_FLAGS <= '0;
                OUT_VALID <= 1'b1;
                state     <= ST_DONE;
              end
              default: begin
                if ((IN_MANT == '0) && !IN_STICKY) begin
                  OUT_FMSUB <= '0;
                  OUT_FLAGS <= FL_W'(1) << FL_ZERO;
                  OUT_VALID <= 1'b1;
                  state     <= ST_DONE;
                end else begin
                  state <= ST_NORM;
                end
              end
            endcase
          end
        end
        ST_NORM: begin
          // Carry bit or exponent below 1: shift right, collecting lost bits in sticky
          if (mant_q[47] || (exp_q < ONE_X)) begin
            mant_q   <= mant_q >> 1;
            sticky_q <= sticky_q | mant_q[0];
            exp_q    <= exp_q + ONE_X;
          end else if (!mant_q[46] && (exp_q > ONE_X)) begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - ONE_X;
          end else begin
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          OUT_FMSUB <= rnd_word;
          OUT_FLAGS <= rnd_flags;
          OUT_VALID <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fms_norm_round.sv
// Directed-vector bench for fms_norm_round: results, flags, latency,
// backpressure and reset behaviour.
module tb_fms_norm_round;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic        IN_SIGN;
  logic [9:0]  IN_EXP;
  logic [47:0] IN_MANT;
  logic        IN_STICKY;
  logic [1:0]  IN_SPECIAL;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_FMSUB;
  logic [4:0]  OUT_FLAGS;

  int tests  = 0;
  int failed = 0;

  fms_norm_round dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_SIGN    (IN_SIGN),
    .IN_EXP     (IN_EXP),
    .IN_MANT    (IN_MANT),
    .IN_STICKY  (IN_STICKY),
    .IN_SPECIAL (IN_SPECIAL),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_FMSUB  (OUT_FMSUB),
    .OUT_FLAGS  (OUT_FLAGS)
  );

  always #5 CLK = ~CLK;

  // Present one transaction, then count edges from the accepting edge to OUT_VALID
  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                      input logic st, input logic [1:0] sp, output int latency);
    int w;
    w = 0;
    while (!IN_READY && w < 100) begin
      @(posedge CLK); #1;
      w++;
    end
    if (!IN_READY) begin
      tests++; failed++;
      $display("FAIL send_in_ready_timeout: IN_READY=%b required 1", IN_READY);
    end
    IN_SIGN = s; IN_EXP = e; IN_MANT = m; IN_STICKY = st; IN_SPECIAL = sp;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    latency = 1;
    while (!OUT_VALID && latency < 200) begin
      @(posedge CLK); #1;
      latency++;
    end
  endtask

  task automatic pop();
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    IN_SIGN = 1'b0; IN_EXP = '0; IN_MANT = '0; IN_STICKY = 1'b0; IN_SPECIAL = 2'b00;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    tests++; if (OUT_VALID !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
    tests++; if (IN_READY !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
    tests++; if (OUT_FMSUB !== 32'h0) begin failed++; $display("FAIL reset_fmsub: got %h want 00000000", OUT_FMSUB); end
    tests++; if (OUT_FLAGS !== 5'h0) begin failed++; $display("FAIL reset_flags: got %h want 00", OUT_FLAGS); end
  endtask

  task automatic test_normalized();
    int lat;
    send(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 2'b00, lat);
    tests++; if (OUT_FMSUB !== 32'h3F80_0000) begin failed++; $display("FAIL one_word: got %h want 3f800000", OUT_FMSUB); end
    tests++; if (OUT_FLAGS !== 5'h00) begin failed++; $display("FAIL one_flags: got %h want 00", OUT_FLAGS); end
    tests++; if (lat != 3) begin failed++; $display("FAIL one_latency: got %0d want 3", lat); end
    pop();
  endtask

  task automatic test_shift();
    int lat;
    send(1'b0, 10'd127, 48'h8000_0000_0000, 1'b0, 2'b00, lat);
    tests++; if (OUT_FMSUB !== 32'h4000_0000) begin failed++; $display("FAIL rshift_word: got %h want 40000000", OUT_FMSUB); end
    tests++; if (OUT_FLAGS !== 5'h00) begin failed++; $display("FAIL rshift_flags: got %h want 00", OUT_FLAGS); end
    tests++; if (lat != 4) begin failed++; $display("FAIL rshift_latency: got %0d want 4", lat); end
    pop();
    // 2^-2 presented two bits low: two left shifts
    send(1'b1, 10'd127, 48'h1000_0000_0000, 1'b0, 2'b00, lat);
    tests++; if (OUT_FMSUB !== 32'hBE80_0000) begin failed++; $display("FAIL lshift_word: got %h want be800000", OUT_FMSUB); end
    tests++; if (lat != 5) begin failed++; $display("FAIL lshift_latency: got %0d want 5", lat); end
    pop();
  endtask

  task automatic test_rne();
    int lat;
    send(1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 2'b00, lat);
    tests++; if (OUT_FMSUB !== 32'h3F80_0000) begin failed++; $display("FAIL tie_even_word: got %h want 3f800000", OUT_FMSUB); end
    tests++; if (OUT_FLAGS !== 5'h01) begin failed++; $display("FAIL tie_even_flags: got %h want 01", OUT_FLAGS); end
    pop();
    send(1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 2'b00, lat);
    tests++; if (OUT_FMSUB !== 32'h3F80_0002) begin failed++; $display("FAIL tie_odd_word: got %h want 3f800002", OUT_FMSUB); end
    tests++; if (OUT_FLAGS !== 5'h01) begin failed++; $display("FAIL tie_odd_flags: got %h want 01", OUT_FLAGS); end
    pop();
    // Below-half with only upstream sticky set: truncate, still inexact
    send(1'b0, 10'd127, 48'h4000_0000_0000, 1'b1, 2'b00, lat);
    tests++; if (OUT_FMSUB !== 32'h3F80_0000) begin failed++; $display("FAIL sticky_word: got %h want 3f800000", OUT_FMSUB); end
    tests++; if (OUT_FLAGS !== 5'h01) begin failed++; $display("FAIL sticky_flags: got %h want 01", OUT_FLAGS); end
    pop();
  endtask

  task automatic test_overflow();
    int lat;
    send(1'b0, 10'd254, 48'h7FFF_FFFF_FFFF, 1'b0, 2'b00, lat);
    tests++; if (OUT_FMSUB !== 32'h7F80_0000) begin failed++; $display("FAIL ovf_word: got %h want 7f800000", OUT_FMSUB); end
    tests++; if (OUT_FLAGS !== 5'h15) begin failed++; $display("FAIL ovf_flags: got %h want 15", OUT_FLAGS); end
    pop();
  endtask

  task automatic test_subnormal();
    int lat;
    send(1'b0, 10'h3FE, 48'h4000_0000_0000, 1'b0, 2'b00, lat);
    tests++; if (OUT_FMSUB !== 32'h0010_0000) begin failed++; $display("FAIL sub_word: got %h want 00100000", OUT_FMSUB); end
    tests++; if (OUT_FLAGS !== 5'h00) begin failed++; $display("FAIL sub_flags: got %h want 00", OUT_FLAGS); end
    tests++; if (lat != 6) begin failed++; $display("FAIL sub_latency: got %0d want 6", lat); end
    pop();
    send(1'b0, 10'h3FE, 48'h4000_0000_0001, 1'b0, 2'b00, lat);
    tests++; if (OUT_FMSUB !== 32'h0010_0000) begin failed++; $display("FAIL sub_nx_word: got %h want 00100000", OUT_FMSUB); end
    tests++; if (OUT_FLAGS !== 5'h03) begin failed++; $display("FAIL sub_nx_flags: got %h want 03", OUT_FLAGS); end
    pop();
  endtask

  task automatic test_special();
    int lat;
    send(1'b1, 10'd127, 48'h4000_0000_0000, 1'b0, 2'b11, lat);
    tests++; if (OUT_FMSUB !== 32'h7FC0_0000) begin failed++; $display("FAIL nan_word: got %h want 7fc00000", OUT_FMSUB); end
    tests++; if (OUT_FLAGS !== 5'h00) begin failed++; $display("FAIL nan_flags: got %h want 00", OUT_FLAGS); end
    tests++; if (lat != 1) begin failed++; $display("FAIL nan_latency: got %0d want 1", lat); end
    pop();
    send(1'b1, 10'd5, 48'h1234, 1'b0, 2'b01, lat);
    tests++; if (OUT_FMSUB !== 32'h8000_0000 || OUT_FLAGS !== 5'h08) begin
      failed++; $display("FAIL zero_special: got %h/%h want 80000000/08", OUT_FMSUB, OUT_FLAGS); end
    pop();
    send(1'b1, 10'd5, 48'h1234, 1'b0, 2'b10, lat);
    tests++; if (OUT_FMSUB !== 32'hFF80_0000 || OUT_FLAGS !== 5'h10) begin
      failed++; $display("FAIL inf_special: got %h/%h want ff800000/10", OUT_FMSUB, OUT_FLAGS); end
    pop();
    send(1'b1, 10'd127, 48'h0, 1'b0, 2'b00, lat);
    tests++; if (OUT_FMSUB !== 32'h0000_0000 || OUT_FLAGS !== 5'h08 || lat != 1) begin
      failed++; $display("FAIL zero_mant: got %h/%h lat %0d want 00000000/08 lat 1", OUT_FMSUB, OUT_FLAGS, lat); end
    pop();
  endtask

  task automatic test_backpressure();
    int lat;
    send(1'b0, 10'd0, 48'h0, 1'b0, 2'b11, lat);
    // Offer a competing input while the result is held; it must not be taken
    IN_SPECIAL = 2'b10; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      tests++;
      if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || OUT_FMSUB !== 32'h7FC0_0000) begin
        failed++;
        $display("FAIL hold_%0d: valid %b ready %b word %h want 1 0 7fc00000", i, OUT_VALID, IN_READY, OUT_FMSUB);
      end
    end
    IN_VALID = 1'b0;
    pop();
    tests++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      failed++; $display("FAIL after_pop: valid %b ready %b want 0 1", OUT_VALID, IN_READY); end
  endtask

  task automatic test_back_to_back();
    int lat;
    send(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 2'b00, lat);
    pop();
    send(1'b0, 10'd127, 48'h8000_0000_0000, 1'b0, 2'b00, lat);
    tests++; if (OUT_FMSUB !== 32'h4000_0000 || lat != 4) begin
      failed++; $display("FAIL b2b_second: got %h lat %0d want 40000000 lat 4", OUT_FMSUB, lat); end
    pop();
  endtask

  task automatic test_reset_midop();
    bit seen;
    IN_SIGN = 1'b0; IN_EXP = 10'h3FE; IN_MANT = 48'h4000_0000_0000; IN_STICKY = 1'b0;
    IN_SPECIAL = 2'b00; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    tests++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || OUT_FMSUB !== 32'h0) begin
      failed++; $display("FAIL midop_reset: valid %b ready %b word %h want 0 1 00000000", OUT_VALID, IN_READY, OUT_FMSUB); end
    seen = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (OUT_VALID === 1'b1) seen = 1'b1;
    end
    tests++; if (seen) begin failed++; $display("FAIL midop_dropped: OUT_VALID seen 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_normalized();
    test_shift();
    test_rne();
    test_overflow();
    test_subnormal();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_normalized();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
